// File: rtl/csa_stream_acc_if.sv
// Beat-in / result-out handshake bundle for csa_stream_acc.
// out_count exists only when CSA_ACC_CNT_EN is defined.
interface csa_stream_acc_if #(
    parameter int IN_W  = 5,
    parameter int ACC_W = 10,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_e;
    logic [IN_W-1:0]  in_f;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
`ifdef CSA_ACC_CNT_EN
    logic [CNT_W-1:0] out_count;
`endif

    // Upstream producer and downstream consumer seen from the bench side
    modport master (
        output in_valid, in_e, in_f, in_last, out_ready,
        input  in_ready, out_valid, out_data
`ifdef CSA_ACC_CNT_EN
        , out_count
`endif
    );

    modport slave (
        input  in_valid, in_e, in_f, in_last, out_ready,
        output in_ready, out_valid, out_data
`ifdef CSA_ACC_CNT_EN
        , out_count
`endif
    );
endinterface

// File: rtl/csa_stream_acc.sv
// Packet accumulator over carry-save beats (e + 2f): per-beat 4:2 compression into S/C, one CPA on the last beat.
// Result held under valid/ready; macro CSA_ACC_CNT_EN adds the saturating out_count beat counter.
module csa_stream_acc #(
    parameter int IN_W  = 5,
    parameter int ACC_W = 10,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    csa_stream_acc_if.slave   bus
);
    typedef enum logic [1:0] {ACCUM, RESOLVE, HOLD} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] s_q, s_d;
    logic [ACC_W-1:0] c_q, c_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;

    logic [ACC_W-1:0] op_e, op_f;
    logic [ACC_W-1:0] l1_s, l1_c, l2_s, l2_c;

    assign op_e = ACC_W'(bus.in_e);
    assign op_f = ACC_W'(bus.in_f) << 1;

    // Carries are shifted to final weight at each level; the dropped MSB is the mod 2^ACC_W wrap
    assign l1_s = s_q ^ c_q ^ op_e;
    assign l1_c = ((s_q & c_q) | (s_q & op_e) | (c_q & op_e)) << 1;
    assign l2_s = l1_s ^ l1_c ^ op_f;
    assign l2_c = ((l1_s & l1_c) | (l1_s & op_f) | (l1_c & op_f)) << 1;

`ifdef CSA_ACC_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc       = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    assign bus.out_count = out_cnt_q;
`endif

    assign bus.out_data = out_data_q;

    always_comb begin
        state_d       = state_q;
        s_d           = s_q;
        c_d           = c_q;
        out_data_d    = out_data_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
`ifdef CSA_ACC_CNT_EN
        cnt_d         = cnt_q;
        out_cnt_d     = out_cnt_q;
`endif
        case (state_q)
            ACCUM: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    s_d = l2_s;
                    c_d = l2_c;
`ifdef CSA_ACC_CNT_EN
                    cnt_d = cnt_inc;
`endif
                    if (bus.in_last) begin
                        state_d = RESOLVE;
                    end
                end
            end
            RESOLVE: begin
                out_data_d = s_q + c_q;
`ifdef CSA_ACC_CNT_EN
                out_cnt_d  = cnt_q;
`endif
                state_d    = HOLD;
            end
            HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    s_d     = '0;
                    c_d     = '0;
`ifdef CSA_ACC_CNT_EN
                    cnt_d   = '0;
`endif
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ACCUM;
            s_q        <= '0;
            c_q        <= '0;
            out_data_q <= '0;
`ifdef CSA_ACC_CNT_EN
            cnt_q      <= '0;
            out_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            c_q        <= c_d;
            out_data_q <= out_data_d;
`ifdef CSA_ACC_CNT_EN
            cnt_q      <= cnt_d;
            out_cnt_q  <= out_cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_csa_stream_acc.sv
// Scoreboard bench for csa_stream_acc: a behavioural e + 2f packet sum predicts each result.
// Inputs are driven and outputs sampled on the falling edge.
module tb_csa_stream_acc;
    localparam int IN_W  = 5;
    localparam int ACC_W = 10;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    csa_stream_acc_if #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus();

    csa_stream_acc #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [ACC_W-1:0] model_sum = '0;
    logic [CNT_W-1:0] model_cnt = '0;
    logic [ACC_W-1:0] exp_data_q[$];
    logic [CNT_W-1:0] exp_cnt_q[$];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer one beat until accepted; the model absorbs it on the accepting edge
    task automatic drive_beat(input logic [IN_W-1:0] e, input logic [IN_W-1:0] f, input logic last);
        bit fired = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_e     = e;
        bus.in_f     = f;
        bus.in_last  = last;
        for (int i = 0; i < 40 && !fired; i++) begin
            fired = bus.in_ready;
            @(negedge clk);
        end
        if (!fired) begin
            checks++;
            failures++;
            $display("FAIL beat_accept: in_ready never rose for beat e=%0d f=%0d", e, f);
        end else begin
            model_sum = model_sum + ACC_W'(e) + (ACC_W'(f) << 1);
            if (model_cnt != {CNT_W{1'b1}}) model_cnt = model_cnt + CNT_W'(1);
            if (last) begin
                exp_data_q.push_back(model_sum);
                exp_cnt_q.push_back(model_cnt);
                model_sum = '0;
                model_cnt = '0;
            end
        end
        if (last) bus.in_valid = 1'b0;
    endtask

    task automatic get_result(output bit got, output logic [ACC_W-1:0] d,
                              output logic [CNT_W-1:0] c, output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        got = bus.out_valid;
        d   = bus.out_data;
`ifdef CSA_ACC_CNT_EN
        c   = bus.out_count;
`else
        c   = '0;
`endif
    endtask

    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.in_e      = '0;
        bus.in_f      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_sum = '0;
        model_cnt = '0;
        exp_data_q.delete();
        exp_cnt_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++;
        if (bus.out_data !== '0) begin failures++; $display("FAIL reset_out_data: got %0d want 0", bus.out_data); end
`ifdef CSA_ACC_CNT_EN
        checks++;
        if (bus.out_count !== '0) begin failures++; $display("FAIL reset_out_count: got %0d want 0", bus.out_count); end
`endif
    endtask

    task automatic test_single();
        bit got; logic [ACC_W-1:0] d, ed; logic [CNT_W-1:0] c, ec; int lat;
        drive_beat(5'd3, 5'd1, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            failures++; $display("FAIL single_resolve: out_valid=%b in_ready=%b want 0 0", bus.out_valid, bus.in_ready);
        end
        get_result(got, d, c, lat);
        ed = exp_data_q.pop_front(); ec = exp_cnt_q.pop_front();
        checks++;
        if (!got || lat != 1) begin failures++; $display("FAIL single_latency: got=%b lat=%0d want valid after 1 more cycle", got, lat); end
        checks++;
        if (d !== ed) begin failures++; $display("FAIL single_data: got %0d want %0d", d, ed); end
`ifdef CSA_ACC_CNT_EN
        checks++;
        if (c !== ec) begin failures++; $display("FAIL single_count: got %0d want %0d", c, ec); end
`endif
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++; $display("FAIL single_release: out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
        end
        checks++;
        if (bus.out_data !== ed) begin failures++; $display("FAIL single_data_keep: got %0d want %0d", bus.out_data, ed); end
    endtask

    task automatic test_back_to_back();
        bit got; logic [ACC_W-1:0] d, ed; logic [CNT_W-1:0] c, ec; int lat;
        drive_beat(5'd3, 5'd1, 1'b0);
        drive_beat(5'd31, 5'd31, 1'b0);
        drive_beat(5'd0, 5'd0, 1'b1);
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_resolve: got %b want 0", bus.in_ready); end
        get_result(got, d, c, lat);
        ed = exp_data_q.pop_front(); ec = exp_cnt_q.pop_front();
        checks++;
        if (!got || bus.in_ready !== 1'b0) begin failures++; $display("FAIL b2b_hold: valid=%b in_ready=%b want 1 0", got, bus.in_ready); end
        checks++;
        if (d !== ed) begin failures++; $display("FAIL b2b_data: got %0d want %0d", d, ed); end
`ifdef CSA_ACC_CNT_EN
        checks++;
        if (c !== ec) begin failures++; $display("FAIL b2b_count: got %0d want %0d", c, ec); end
`endif
        @(negedge clk);
    endtask

    task automatic test_wrap();
        bit got; logic [ACC_W-1:0] d, ed; logic [CNT_W-1:0] c, ec; int lat;
        for (int i = 0; i < 12; i++) drive_beat(5'd31, 5'd31, (i == 11));
        get_result(got, d, c, lat);
        ed = exp_data_q.pop_front(); ec = exp_cnt_q.pop_front();
        checks++;
        if (!got || d !== ed) begin failures++; $display("FAIL wrap_data: valid=%b got %0d want %0d", got, d, ed); end
`ifdef CSA_ACC_CNT_EN
        checks++;
        if (c !== ec) begin failures++; $display("FAIL wrap_count: got %0d want %0d", c, ec); end
`endif
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit got; logic [ACC_W-1:0] d, ed; logic [CNT_W-1:0] c, ec; int lat;
        int bad = 0;
        bus.out_ready = 1'b0;
        drive_beat(5'd2, 5'd0, 1'b1);
        bus.in_valid = 1'b1; bus.in_e = 5'd1; bus.in_f = 5'd0; bus.in_last = 1'b0;
        get_result(got, d, c, lat);
        ed = exp_data_q.pop_front(); ec = exp_cnt_q.pop_front();
        checks++;
        if (!got || d !== ed) begin failures++; $display("FAIL bp_data: valid=%b got %0d want %0d", got, d, ed); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_data !== ed) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL bp_stall: %0d unstable cycles, want 0 (out_data=%0d want %0d)", bad, bus.out_data, ed); end
        bus.out_ready = 1'b1;
        drive_beat(5'd1, 5'd0, 1'b0);
        drive_beat(5'd0, 5'd0, 1'b1);
        get_result(got, d, c, lat);
        ed = exp_data_q.pop_front(); ec = exp_cnt_q.pop_front();
        checks++;
        if (!got || d !== ed) begin failures++; $display("FAIL bp_next_data: valid=%b got %0d want %0d", got, d, ed); end
`ifdef CSA_ACC_CNT_EN
        checks++;
        if (c !== ec) begin failures++; $display("FAIL bp_next_count: got %0d want %0d", c, ec); end
`endif
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit got; logic [ACC_W-1:0] d, ed; logic [CNT_W-1:0] c, ec; int lat;
        drive_beat(5'd10, 5'd10, 1'b0);
        drive_beat(5'd5, 5'd0, 1'b0);
        bus.in_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_sum = '0;
        model_cnt = '0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
            failures++; $display("FAIL midreset_state: in_ready=%b out_valid=%b out_data=%0d want 1 0 0", bus.in_ready, bus.out_valid, bus.out_data);
        end
        drive_beat(5'd7, 5'd0, 1'b1);
        get_result(got, d, c, lat);
        ed = exp_data_q.pop_front(); ec = exp_cnt_q.pop_front();
        checks++;
        if (!got || d !== ed) begin failures++; $display("FAIL midreset_data: valid=%b got %0d want %0d", got, d, ed); end
`ifdef CSA_ACC_CNT_EN
        checks++;
        if (c !== ec) begin failures++; $display("FAIL midreset_count: got %0d want %0d", c, ec); end
`endif
        @(negedge clk);
    endtask

    task automatic test_gaps();
        bit got; logic [ACC_W-1:0] d, ed; logic [CNT_W-1:0] c, ec; int lat;
        int bad = 0;
        drive_beat(5'd1, 5'd0, 1'b0);
        bus.in_valid = 1'b0;
        bus.in_e = 5'd31; bus.in_f = 5'd31; bus.in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL gaps_idle: %0d bad idle cycles, want 0", bad); end
        drive_beat(5'd0, 5'd2, 1'b1);
        get_result(got, d, c, lat);
        ed = exp_data_q.pop_front(); ec = exp_cnt_q.pop_front();
        checks++;
        if (!got || d !== ed) begin failures++; $display("FAIL gaps_data: valid=%b got %0d want %0d", got, d, ed); end
`ifdef CSA_ACC_CNT_EN
        checks++;
        if (c !== ec) begin failures++; $display("FAIL gaps_count: got %0d want %0d", c, ec); end
`endif
        @(negedge clk);
        checks++;
        if (exp_data_q.size() != 0) begin failures++; $display("FAIL scoreboard_drain: %0d results left, want 0", exp_data_q.size()); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_gaps();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
